// File: rtl/adder_pkg.sv
// Shared constants, saturation helpers and the stage payload carried down the
// pipelined wide adder.
package adder_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;
   // Payload fields are sized for the widest supported operand.
   localparam int MAX_WIDTH = 64;

   function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
      logic [MAX_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_WIDTH; i++)
         if (i < width - 1) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
      logic [MAX_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_WIDTH; i++)
         if (i == width - 1) m[i] = 1'b1;
      return m;
   endfunction

   typedef struct packed {
      logic                 vld;
      logic                 sat;
      logic                 sa;
      logic                 sb;
      logic                 cy;
      logic [MAX_WIDTH-1:0] psum;
      logic [MAX_WIDTH-1:0] ua;
      logic [MAX_WIDTH-1:0] ub;
   } stage_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit add with carry in and carry out.
module adder_chunk
   import adder_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit carry segment per stage, with a
// global stall and optional signed saturation applied ahead of the output register.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam logic [MAX_WIDTH-1:0] SMAX = sat_max(WIDTH);
   localparam logic [MAX_WIDTH-1:0] SMIN = sat_min(WIDTH);

   // stg_q[STAGES-1] doubles as the output register.
   stage_t stg_q [STAGES];
   logic   ovf_q;
   logic   advance;

   assign out_valid = stg_q[STAGES-1].vld;
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign sum       = stg_q[STAGES-1].psum[WIDTH-1:0];
   assign cout      = stg_q[STAGES-1].cy;
   assign overflow  = ovf_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t           src;
      stage_t           nxt;
      logic [CHUNK-1:0] csum;
      logic             cout_c;

      if (k == 0) begin : g_src_in
         always_comb begin
            src     = '0;
            src.vld = in_valid;
            src.sat = sat;
            src.sa  = a[WIDTH-1];
            src.sb  = b[WIDTH-1];
            src.cy  = cin;
            src.ua  = MAX_WIDTH'(a);
            src.ub  = MAX_WIDTH'(b);
         end
      end else begin : g_src_stg
         assign src = stg_q[k-1];
      end

      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a    (src.ua[CHUNK-1:0]),
         .b    (src.ub[CHUNK-1:0]),
         .cin  (src.cy),
         .sum  (csum),
         .cout (cout_c)
      );

      // Operands shift down so the next chunk to add always sits at bit 0.
      always_comb begin
         nxt                        = src;
         nxt.ua                     = src.ua >> CHUNK;
         nxt.ub                     = src.ub >> CHUNK;
         nxt.cy                     = cout_c;
         nxt.psum[k*CHUNK +: CHUNK] = csum;
      end

      if (k == STAGES - 1) begin : g_last
         logic ovf;
         assign ovf = (src.sa == src.sb) && (nxt.psum[WIDTH-1] != src.sa);

         always_ff @(posedge clk) begin
            if (rst) begin
               stg_q[k] <= '0;
               ovf_q    <= 1'b0;
            end else if (advance) begin
               if (src.vld) begin
                  stg_q[k] <= nxt;
                  ovf_q    <= ovf;
                  if (src.sat && ovf)
                     stg_q[k].psum <= src.sa ? SMIN : SMAX;
               end else begin
                  stg_q[k].vld <= 1'b0;
               end
            end
         end
      end else begin : g_mid
         always_ff @(posedge clk) begin
            if (rst) begin
               stg_q[k] <= '0;
            end else if (advance) begin
               if (src.vld)
                  stg_q[k] <= nxt;
               else
                  stg_q[k].vld <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe at 16/4, 32/8 and 8/8: directed corner beats, stall
// stream, mid-flight reset and a random stream against an integer-arithmetic model.
module tb_adder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errs   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: {overflow, cout, sum} from signed-range and unsigned-carry arithmetic.
   function automatic logic [65:0] ref_add(input int w, input logic [63:0] a,
                                           input logic [63:0] b, input logic ci,
                                           input logic st);
      logic [63:0] mask, raw, s;
      longint      sa, sb, sv, hi, lo;
      logic        co, ov;
      mask = (64'd1 << w) - 64'd1;
      raw  = (a & mask) + (b & mask) + 64'(ci);
      co   = raw[w];
      sa   = a[w-1] ? longint'(a & mask) - longint'(64'd1 << w) : longint'(a & mask);
      sb   = b[w-1] ? longint'(b & mask) - longint'(64'd1 << w) : longint'(b & mask);
      hi   = longint'((64'd1 << (w - 1)) - 64'd1);
      lo   = -hi - 1;
      sv   = sa + sb + longint'(ci);
      ov   = (sv > hi) || (sv < lo);
      s    = raw & mask;
      if (st && ov) s = (sv > hi) ? 64'(hi) : (64'(lo) & mask);
      return {ov, co, s};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W   = (g == 0) ? 16 : (g == 1) ? 32 : 8;
      localparam int C   = (g == 0) ? 4 : 8;
      localparam int LAT = W / C;

      logic         rst, in_valid, in_ready, cin, sat;
      logic         out_valid, out_ready, cout, overflow;
      logic [W-1:0] a, b, sum;
      logic         done = 1'b0;
      logic [65:0]  q[$];

      adder_pipe #(.WIDTH(W), .CHUNK(C)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .a         (a),
         .b         (b),
         .cin       (cin),
         .sat       (sat),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .sum       (sum),
         .cout      (cout),
         .overflow  (overflow)
      );

      initial begin
         logic [W-1:0] maxv, minv, hsum;
         logic [W-1:0] da[5], db[5], es[5];
         logic         dc[5], ds[5], ec[5], eo[5];
         logic         hcout, hovf, held;
         logic [65:0]  e;
         int           n, sent, rcvd, cyc, nb;
         string        tg;

         tg = $sformatf("w%0d/c%0d", W, C);
         rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
         a = '0; b = '0; cin = 1'b0; sat = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         chk({tg, " rst out_valid"}, 64'(out_valid), 64'd0);
         chk({tg, " rst sum"}, 64'(sum), 64'd0);
         chk({tg, " rst cout"}, 64'(cout), 64'd0);
         chk({tg, " rst overflow"}, 64'(overflow), 64'd0);
         rst = 1'b0;
         #1;
         chk({tg, " in_ready after rst"}, 64'(in_ready), 64'd1);

         // Directed corner beats, one at a time with out_ready high.
         maxv  = {1'b0, {(W-1){1'b1}}};
         minv  = {1'b1, {(W-1){1'b0}}};
         da[0] = W'(64'h1234_5678_9ABC_DEF0 >> (64 - W));
         db[0] = W'(64'h5678_9ABC_DEF0_1234 >> (64 - W));
         es[0] = W'(64'h68AC_F134_0000_0000 >> (64 - W));
         da[1] = minv; db[1] = minv; es[1] = '0;
         da[2] = minv; db[2] = minv; es[2] = minv;
         da[3] = maxv; db[3] = '0;   es[3] = maxv;
         da[4] = '1;   db[4] = '1;   es[4] = '1;
         dc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
         ds = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
         ec = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
         eo = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
         for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            a = da[v]; b = db[v]; cin = dc[v]; sat = ds[v];
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            chk($sformatf("%s v%0d latency", tg, v), 64'(n), 64'(LAT));
            chk($sformatf("%s v%0d sum", tg, v), 64'(sum), 64'(es[v]));
            chk($sformatf("%s v%0d cout", tg, v), 64'(cout), 64'(ec[v]));
            chk($sformatf("%s v%0d overflow", tg, v), 64'(overflow), 64'(eo[v]));
         end

         // ph 0: 8-beat stream with a 3-cycle stall; ph 1: random stream.
         for (int ph = 0; ph < 2; ph++) begin
            nb = (ph == 0) ? 8 : 10000;
            sent = 0; rcvd = 0; cyc = 0; held = 1'b0; q.delete();
            hsum = '0; hcout = 1'b0; hovf = 1'b0;
            while ((sent < nb || rcvd < sent) && cyc < nb * 6 + 100) begin
               @(negedge clk);
               out_ready = (ph == 0) ? !(cyc >= 6 && cyc < 9) : ($urandom_range(3) != 0);
               in_valid  = (sent < nb) && (ph == 0 || $urandom_range(3) != 0);
               a   = W'({$urandom, $urandom});
               b   = W'({$urandom, $urandom});
               cin = 1'($urandom);
               sat = 1'($urandom);
               #1;
               if (held) begin
                  chk({tg, " hold out_valid"}, 64'(out_valid), 64'd1);
                  chk({tg, " hold sum"}, 64'(sum), 64'(hsum));
                  chk({tg, " hold cout"}, 64'(cout), 64'(hcout));
                  chk({tg, " hold overflow"}, 64'(overflow), 64'(hovf));
               end
               chk({tg, " in_ready"}, 64'(in_ready), 64'(!out_valid || out_ready));
               if (ph == 0 && !out_ready)
                  chk({tg, " stall in_ready"}, 64'(in_ready), 64'd0);
               if (out_valid && out_ready) begin
                  if (q.size() == 0) begin
                     chk({tg, " spurious beat"}, 64'(out_valid), 64'd0);
                  end else begin
                     e = q.pop_front();
                     chk({tg, " stream sum"}, 64'(sum), e[63:0]);
                     chk({tg, " stream cout"}, 64'(cout), 64'(e[64]));
                     chk({tg, " stream overflow"}, 64'(overflow), 64'(e[65]));
                  end
                  rcvd++;
               end
               held  = out_valid && !out_ready;
               hsum  = sum;
               hcout = cout;
               hovf  = overflow;
               if (in_valid && in_ready) begin
                  q.push_back(ref_add(W, 64'(a), 64'(b), cin, sat));
                  sent++;
               end
               cyc++;
            end
            chk($sformatf("%s ph%0d beats sent", tg, ph), 64'(sent), 64'(nb));
            chk($sformatf("%s ph%0d beats received", tg, ph), 64'(rcvd), 64'(nb));

            if (ph == 0) begin
               // Reset with three beats in flight: nothing may emerge afterwards.
               for (int i = 0; i < 3; i++) begin
                  @(negedge clk);
                  in_valid = 1'b1; out_ready = 1'b1;
                  a = W'({$urandom, $urandom}) | W'(1);
                  b = W'({$urandom, $urandom});
               end
               @(negedge clk);
               in_valid = 1'b0; rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
               chk({tg, " midrst out_valid"}, 64'(out_valid), 64'd0);
               chk({tg, " midrst sum"}, 64'(sum), 64'd0);
               chk({tg, " midrst cout"}, 64'(cout), 64'd0);
               chk({tg, " midrst overflow"}, 64'(overflow), 64'd0);
               for (int i = 0; i < 10; i++) begin
                  @(negedge clk);
                  chk({tg, " stale beat"}, 64'(out_valid), 64'd0);
               end
            end
         end
         done = 1'b1;
      end
   end

   initial begin
      int c;
      c = 0;
      while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && c < 90000) begin
         @(posedge clk);
         c++;
      end
      chk("all configs finished", 64'(c < 90000), 64'd1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
